// File: rtl/cvp14_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cvp14_pkg
//  Purpose  : Shared CVP14 definitions: vector geometry, load/store opcodes
//             and the vector load/store sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cvp14_pkg;

    localparam int VLEN  = 16;              // elements per vector register
    localparam int W     = 16;              // element and address width
    localparam int IDX_W = $clog2(VLEN);    // element index width

    localparam logic [3:0] VLD = 4'b0100;   // vector load opcode
    localparam logic [3:0] VST = 4'b0101;   // vector store opcode

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        REQ   = 3'd3,
        WRREG = 3'd4,
        DONE  = 3'd5
    } vls_state_t;

endpackage : cvp14_pkg
`default_nettype wire

// File: rtl/vls_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : vls_seq_if
//  Purpose  : Bundles the command, memory-port and register-file serial-port
//             signals of the vector load/store sequencer.
//  Modports : master - command source / memory / register file side
//             slave  - the sequencer itself
//  Options  : VLS_STRIDE_EN adds the 8-bit signed stride command field.
//  Revision : 1.0 - initial release
// ============================================================================
interface vls_seq_if;
    import cvp14_pkg::*;

    // command
    logic                start;
    logic                op;        // 0 = load, 1 = store
    logic [W-1:0]        base;
    logic [5:0]          imm;
    logic [2:0]          vreg;
`ifdef VLS_STRIDE_EN
    logic [7:0]          stride;
`endif
    // memory port
    logic                mem_ack;
    logic [W-1:0]        DataIn;
    logic [W-1:0]        Addr;
    logic                RD;
    logic                WR;
    logic [W-1:0]        DataOut;
    // register-file serial port
    logic [W-1:0]        vOutS;
    logic [2:0]          vAddr;
    logic [IDX_W-1:0]    vElem;
    logic                vRD_s;
    logic                vWR_s;
    logic [W-1:0]        vInS;
    // status
    logic                busy;
    logic                done;

    modport master (
`ifdef VLS_STRIDE_EN
        output stride,
`endif
        output start, op, base, imm, vreg, mem_ack, DataIn, vOutS,
        input  Addr, RD, WR, DataOut, vAddr, vElem, vRD_s, vWR_s, vInS,
        input  busy, done
    );

    modport slave (
`ifdef VLS_STRIDE_EN
        input  stride,
`endif
        input  start, op, base, imm, vreg, mem_ack, DataIn, vOutS,
        output Addr, RD, WR, DataOut, vAddr, vElem, vRD_s, vWR_s, vInS,
        output busy, done
    );

endinterface : vls_seq_if
`default_nettype wire

// File: rtl/vls_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vls_addr_gen
//  Purpose  : Address accumulator for the vector load/store sequencer.
//             Loads base + zero-extended imm, then adds a step per element.
//             All arithmetic wraps modulo 2^W with no overflow indication.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             load        - capture base + imm
//             step_en     - add step to the current address
//             base, imm   - start address operands
//             step        - already sign-extended address increment
//             addr        - registered memory address
//  Revision : 1.0 - initial release
// ============================================================================
module vls_addr_gen
    import cvp14_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step_en,
    input  logic [W-1:0]  base,
    input  logic [5:0]    imm,
    input  logic [W-1:0]  step,
    output logic [W-1:0]  addr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= base + {{(W-6){1'b0}}, imm};
        end else if (step_en) begin
            addr <= addr + step;
        end
    end

endmodule : vls_addr_gen
`default_nettype wire

// File: rtl/vls_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vls_seq
//  Purpose  : CVP14 vector load/store sequencer. Moves all VLEN elements of
//             one vector register to (store) or from (load) memory, one
//             element per memory transaction, then pulses done.
//  Ports    : Clk1  - sole clock, rising edge
//             Reset - synchronous, active-high
//             bus   - vls_seq_if.slave: command, memory port, register-file
//                     serial port, busy/done status
//  Options  : VLS_STRIDE_EN - latch a signed 8-bit stride at start and use it
//             as the address step; otherwise the step is fixed at +1.
//  Revision : 1.0 - initial release
// ============================================================================
module vls_seq
    import cvp14_pkg::*;
(
    input  logic       Clk1,
    input  logic       Reset,
    vls_seq_if.slave   bus
);

    vls_state_t          state;
    vls_state_t          state_n;

    logic                op_q;
    logic                op_n;
    logic [2:0]          vreg_q;
    logic [IDX_W-1:0]    idx;
    logic [W-1:0]        vin_q;
    logic [W-1:0]        dout_q;
    logic [W-1:0]        addr;
    logic [W-1:0]        step;

    logic                rd_q;
    logic                wr_q;
    logic                vrd_q;
    logic                vwr_q;
    logic                busy_q;
    logic                done_q;

    logic                accept;    // command taken this cycle
    logic                advance;   // move to the next element
    logic                cap_rd;    // memory read data -> vInS
    logic                cap_wr;    // register-file data -> DataOut
    logic                last;

    assign last = (idx == IDX_W'(VLEN - 1));

`ifdef VLS_STRIDE_EN
    logic [7:0] stride_q;
    assign step = {{(W-8){stride_q[7]}}, stride_q};
`else
    assign step = W'(1);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        advance = 1'b0;
        cap_rd  = 1'b0;
        cap_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = bus.op ? FETCH : REQ;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                // vOutS is valid now, one cycle after the FETCH read strobe
                cap_wr  = 1'b1;
                state_n = REQ;
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (!op_q) begin
                        cap_rd  = 1'b1;
                        state_n = WRREG;
                    end else if (last) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            WRREG: begin
                if (last) begin
                    state_n = DONE;
                end else begin
                    advance = 1'b1;
                    state_n = REQ;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // The operation for the upcoming state, needed to register strobes
        // in the same edge that accepts the command.
        op_n = accept ? bus.op : op_q;
    end

    // ------------------------------------------------------------------
    // State register, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            vreg_q <= '0;
            idx    <= '0;
            vin_q  <= '0;
            dout_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            vrd_q  <= 1'b0;
            vwr_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef VLS_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                op_q   <= bus.op;
                vreg_q <= bus.vreg;
                idx    <= '0;
`ifdef VLS_STRIDE_EN
                stride_q <= bus.stride;
`endif
            end else if (advance) begin
                idx <= idx + 1'b1;
            end
            if (cap_rd) begin
                vin_q <= bus.DataIn;
            end
            if (cap_wr) begin
                dout_q <= bus.vOutS;
            end
            // Strobes decoded from the next state so they line up with it
            rd_q   <= (state_n == REQ) && !op_n;
            wr_q   <= (state_n == REQ) &&  op_n;
            vrd_q  <= (state_n == FETCH);
            vwr_q  <= (state_n == WRREG);
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);
        end
    end

    vls_addr_gen u_addr_gen (
        .clk     (Clk1),
        .rst     (Reset),
        .load    (accept),
        .step_en (advance),
        .base    (bus.base),
        .imm     (bus.imm),
        .step    (step),
        .addr    (addr)
    );

    assign bus.Addr    = addr;
    assign bus.RD      = rd_q;
    assign bus.WR      = wr_q;
    assign bus.DataOut = dout_q;
    assign bus.vAddr   = vreg_q;
    assign bus.vElem   = idx;
    assign bus.vRD_s   = vrd_q;
    assign bus.vWR_s   = vwr_q;
    assign bus.vInS    = vin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule : vls_seq
`default_nettype wire

// File: tb/tb_vls_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vls_seq
//  Purpose  : Self-checking bench for vls_seq. A table of transfers is run
//             with a per-cycle expected strobe/address/data schedule, then
//             hand-written sequences cover reset mid-transfer and start
//             held high during a transfer.
//  Options  : VLS_STRIDE_EN adds strided entries to the table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vls_seq;

    logic Clk1;
    logic Reset;

    vls_seq_if bus ();

    vls_seq dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    // Memory: word at address A holds A[7:0]
    assign bus.DataIn = {8'h00, bus.Addr[7:0]};

    // Register file: element k reads as 0xA000 + k, one cycle after vRD_s
    always @(posedge Clk1) begin
        if (bus.vRD_s) bus.vOutS <= 16'hA000 + {12'h000, bus.vElem};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        op;
        logic [15:0] base;
        logic [5:0]  imm;
        logic [2:0]  vreg;
        int          waits;      // mem_ack low cycles per REQ
        int          stride;
        int          exp_done;   // cycle of the done pulse
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[$];

    task automatic drive_cmd(input logic op, input logic [15:0] base, input logic [5:0] imm,
                             input logic [2:0] vreg, input int stride);
        bus.start = 1'b1;
        bus.op    = op;
        bus.base  = base;
        bus.imm   = imm;
        bus.vreg  = vreg;
`ifdef VLS_STRIDE_EN
        bus.stride = 8'(stride);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        int          per;
        int          k;
        int          p;
        logic [15:0] a;
        logic [3:0]  exp_strb;   // {RD, WR, vRD_s, vWR_s}
        per = v.op ? (3 + v.waits) : (2 + v.waits);
        @(negedge Clk1);
        drive_cmd(v.op, v.base, v.imm, v.vreg, v.stride);
        bus.mem_ack = (v.waits == 0);
        @(negedge Clk1);
        bus.start = 1'b0;
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            if (c > 1) @(negedge Clk1);
            k = (c - 1) / per;
            p = (c - 1) % per;
            a = v.base + {10'h000, v.imm} + 16'(k * v.stride);
            exp_strb = 4'b0000;
            if (c < v.exp_done) begin
                if (!v.op) exp_strb = (p <= v.waits) ? 4'b1000 : 4'b0001;
                else       exp_strb = (p == 0) ? 4'b0010 : (p == 1) ? 4'b0000 : 4'b0100;
            end
            check("strobes", {bus.RD, bus.WR, bus.vRD_s, bus.vWR_s}, exp_strb);
            check("done", bus.done, (c == v.exp_done));
            check("busy", bus.busy, (c <= v.exp_done));
            if (exp_strb[3] | exp_strb[2]) begin
                check("Addr", bus.Addr, a);
                if (k == 0)  check("Addr_first", bus.Addr, v.exp_first);
                if (k == 15) check("Addr_last", bus.Addr, v.exp_last);
            end
            if (exp_strb[2]) check("DataOut", bus.DataOut, 16'hA000 + 16'(k));
            if (exp_strb[1] | exp_strb[0]) begin
                check("vElem", bus.vElem, k);
                check("vAddr", bus.vAddr, v.vreg);
            end
            if (exp_strb[0]) check("vInS", bus.vInS, {8'h00, a[7:0]});
            // acknowledge for the edge that closes this cycle
            if (v.waits == 0) bus.mem_ack = 1'b1;
            else bus.mem_ack = (c < v.exp_done) &&
                               ((!v.op && p == v.waits) || (v.op && p == 2 + v.waits));
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acts;
        int done_cyc;

        vecs.push_back('{1'b0, 16'h0100, 6'd4,  3'd3, 0, 1, 33, 16'h0104, 16'h0113});
        vecs.push_back('{1'b1, 16'h0200, 6'd0,  3'd5, 0, 1, 49, 16'h0200, 16'h020F});
        vecs.push_back('{1'b0, 16'h0100, 6'd4,  3'd1, 2, 1, 65, 16'h0104, 16'h0113});
        vecs.push_back('{1'b0, 16'hFFF8, 6'd0,  3'd7, 0, 1, 33, 16'hFFF8, 16'h0007});
        vecs.push_back('{1'b1, 16'hFFF0, 6'd63, 3'd2, 1, 1, 65, 16'h002F, 16'h003E});
`ifdef VLS_STRIDE_EN
        vecs.push_back('{1'b0, 16'h0040, 6'd0,  3'd4, 0, -2, 33, 16'h0040, 16'h0022});
        vecs.push_back('{1'b1, 16'h0080, 6'd5,  3'd6, 0, 0,  49, 16'h0085, 16'h0085});
`endif

        Reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 1'b0;
        bus.base    = '0;
        bus.imm     = '0;
        bus.vreg    = '0;
        bus.mem_ack = 1'b0;
`ifdef VLS_STRIDE_EN
        bus.stride  = '0;
`endif
        repeat (3) @(posedge Clk1);
        @(negedge Clk1);
        check("reset_strobes", {bus.RD, bus.WR, bus.vRD_s, bus.vWR_s, bus.busy, bus.done}, 0);
        check("reset_Addr", bus.Addr, 0);
        check("reset_data", {bus.DataOut, bus.vInS}, 0);
        check("reset_index", {bus.vAddr, bus.vElem}, 0);
        Reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset at cycle 10 of a store clears everything on that edge
        @(negedge Clk1);
        drive_cmd(1'b1, 16'h1234, 6'd0, 3'd5, 1);
        bus.mem_ack = 1'b1;
        @(negedge Clk1);            // cycle 1
        bus.start = 1'b0;
        repeat (9) @(negedge Clk1); // cycle 10
        check("pre_reset_busy", bus.busy, 1);
        check("pre_reset_DataOut", bus.DataOut, 16'hA002);
        Reset = 1'b1;
        @(negedge Clk1);            // cycle 11
        check("mid_reset_strobes", {bus.RD, bus.WR, bus.vRD_s, bus.vWR_s, bus.busy, bus.done}, 0);
        check("mid_reset_Addr", bus.Addr, 0);
        check("mid_reset_DataOut", bus.DataOut, 0);
        check("mid_reset_vInS", bus.vInS, 0);
        check("mid_reset_index", {bus.vAddr, bus.vElem}, 0);
        Reset = 1'b0;
        acts = 0;
        repeat (60) begin
            @(negedge Clk1);
            if (bus.RD | bus.WR | bus.vRD_s | bus.vWR_s | bus.busy | bus.done) acts++;
        end
        check("quiet_after_reset", acts, 0);
        bus.mem_ack = 1'b0;

        // start held high for the first 20 cycles of a load is ignored
        @(negedge Clk1);
        drive_cmd(1'b0, 16'h0300, 6'd0, 3'd2, 1);
        bus.mem_ack = 1'b1;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk1);
            if (bus.done && done_cyc == 0) done_cyc = c;
            if (c == 31) begin
                check("held_start_RD", bus.RD, 1);
                check("held_start_Addr", bus.Addr, 16'h030F);
            end
            if (c == 20) bus.start = 1'b0;
        end
        check("held_start_done_cycle", done_cyc, 33);
        check("held_start_idle", bus.busy, 0);
        bus.mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vls_seq
`default_nettype wire
